qupls4_fetch_ip_sequencer: RTL and testbench
============================================

// Module: qupls4_fetch_ip_sequencer
// PURPOSE
//  Fetch-side IP sequencer for Qupls4. Holds the fetch IP, requests an instruction-aligned cache line,
//  registers it, and exposes it to the min-constant decoder. Uses the returned nops mask and ip_inc to
//  hand a MWIDTH-slot bundle (with constant slots marked NOP) to decode under valid/ready, then advances IP.
//  Sits between the I-cache line aligner (upstream) and the instruction decoders (downstream).
// PARAMETERS
//  MWIDTH  4                   slots per bundle, 1..4; must match the decoder's MWIDTH
//  RSTIP   32'hFFFFFD00        IP loaded on reset (zero-extended to pc_address_t)
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous reset, active high
//  redirect_i    in   1        branch/exception redirect request
//  redirect_ip   in   PC       new IP (pc_address_t)
//  ic_req        out  1        line request to I-cache
//  ic_ip         out  PC       IP of requested line
//  ic_valid      in   1        I-cache response valid
//  ic_rsp_ip     in   PC       IP the response belongs to
//  ic_line       in   1024     line, instruction at ic_rsp_ip at bits [47:0]
//  cline_o       out  1024     registered line, to min-constant decoder cline_aligned
//  ip_o          out  PC       current fetch IP, to decoder ip
//  nops_i        in   10       constant-slot mask from decoder
//  ip_inc_i      in   7        byte increment from decoder
//  out_valid     out  1        bundle valid
//  out_ready     in   1        decode accepts bundle
//  out_ip        out  PC       IP of slot 0
//  out_inst      out  48*MWIDTH slot n = cline_o[n*48+:48]
//  out_nop       out  MWIDTH   nops_i[MWIDTH-1:0]
//  bundle_cnt    out  32       bundles accepted since reset
// BEHAVIOUR
//  Reset (async): state=ST_REQ, ip=RSTIP, cline_o=0, bundle_cnt=0; ic_req, out_valid low until first clk.
//  States:
//   ST_REQ : ic_req=1, ic_ip=ip. On ic_valid && ic_rsp_ip==ip: cline_o<=ic_line, -> ST_DLV.
//            Responses with ic_rsp_ip!=ip are stale: dropped, remain ST_REQ.
//   ST_DLV : ic_req=0. out_valid = ~redirect_i. out_* driven combinationally from cline_o/nops_i.
//            On out_valid&&out_ready: ip<=ip+inc, bundle_cnt+=1, -> ST_REQ. Else hold, outputs stable.
//  inc = ip_inc_i, except ip_inc_i==0 (illegal) uses 6. Add modulo pc_address_t width (wraps, no trap).
//  Redirect has priority in every state: ip<=redirect_ip, -> ST_REQ next clk; current line discarded;
//   out_valid forced low in redirect cycle, so no bundle is accepted then; bundle_cnt unchanged.
//  Redirect in ST_REQ with ic_valid same cycle: response dropped, even if ic_rsp_ip==ip.
//  Back-to-back redirects: last one wins; ic_req stays high with ic_ip tracking ip.
//  Latency: line accept -> out_valid next clk; accept -> new ic_req next clk (min 2 clk/bundle).
//  out_valid never drops without acceptance except on redirect or reset.
//  bundle_cnt wraps at 2^32.
// TESTING
//  1 reset then ic_valid, rsp_ip=RSTIP, nops=0, ip_inc=24 -> out_valid next clk, out_ip=RSTIP; ready -> ic_ip=RSTIP+24
//  2 DLV with out_ready=0 for 5 clk -> out_valid/out_inst stable, ip unchanged, bundle_cnt unchanged
//  3 nops=10'b0000000110, ip_inc=24 -> out_nop=4'b0110; after accept ip advances by 24
//  4 redirect_i, ip=0x1000, in DLV with out_ready=1 -> out_valid=0 that clk, bundle_cnt unchanged, ic_ip=0x1000 next
//  5 ST_REQ: response rsp_ip=ip-6 -> dropped, ic_req stays 1; then rsp_ip=ip -> ST_DLV
//  6 ip=pc max-5, ip_inc=6 -> ip wraps to 0; ip_inc=0 -> advance by 6; rst mid-DLV -> ip=RSTIP, out_valid=0

Source files
------------

// File: rtl/qupls4_fetch_ip_sequencer.sv
// Qupls4 fetch IP sequencer: requests an aligned line, registers it and
// hands a MWIDTH-slot bundle to decode, then advances the fetch IP.
module qupls4_fetch_ip_sequencer #(
  parameter int MWIDTH = 4,
  parameter int PCW = 32,
  parameter logic [31:0] RSTIP = 32'hFFFFFD00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [PCW-1:0]        redirect_ip,
  output logic                  ic_req,
  output logic [PCW-1:0]        ic_ip,
  input  logic                  ic_valid,
  input  logic [PCW-1:0]        ic_rsp_ip,
  input  logic [1023:0]         ic_line,
  output logic [1023:0]         cline_o,
  output logic [PCW-1:0]        ip_o,
  input  logic [9:0]            nops_i,
  input  logic [6:0]            ip_inc_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PCW-1:0]        out_ip,
  output logic [48*MWIDTH-1:0]  out_inst,
  output logic [MWIDTH-1:0]     out_nop,
  output logic [31:0]           bundle_cnt
);

  typedef logic [PCW-1:0] pc_address_t;
  typedef enum logic {ST_REQ, ST_DLV} state_t;

  state_t        state, state_n;
  pc_address_t   ip, ip_n;
  logic [1023:0] cline_n;
  logic [31:0]   cnt_n;
  logic          live;
  logic [6:0]    inc7;
  pc_address_t   inc;
  logic          unused_nops;

  // A zero increment would stall fetch forever; fall back to one slot.
  assign inc7 = (ip_inc_i == 7'd0) ? 7'd6 : ip_inc_i;
  assign inc  = pc_address_t'(inc7);

  assign ic_ip  = ip;
  assign ip_o   = ip;
  assign out_ip = ip;
  assign out_nop = nops_i[MWIDTH-1:0];
  assign unused_nops = ^nops_i;

  for (genvar n = 0; n < MWIDTH; n++) begin : g_slot
    assign out_inst[n*48+:48] = cline_o[n*48+:48];
  end

  always_comb begin
    state_n   = state;
    ip_n      = ip;
    cline_n   = cline_o;
    cnt_n     = bundle_cnt;
    ic_req    = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_REQ: begin
        ic_req = live;
        if (live && ic_valid && !redirect_i && ic_rsp_ip == ip) begin
          cline_n = ic_line;
          state_n = ST_DLV;
        end
      end
      ST_DLV: begin
        out_valid = ~redirect_i;
        if (out_valid && out_ready) begin
          ip_n    = ip + inc;
          cnt_n   = bundle_cnt + 32'd1;
          state_n = ST_REQ;
        end
      end
      default: ;
    endcase
    // Redirect overrides any line capture or bundle hand-off.
    if (redirect_i) begin
      ip_n    = redirect_ip;
      state_n = ST_REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_REQ;
      ip         <= pc_address_t'(RSTIP);
      cline_o    <= '0;
      bundle_cnt <= '0;
      live       <= 1'b0;
    end else begin
      state      <= state_n;
      ip         <= ip_n;
      cline_o    <= cline_n;
      bundle_cnt <= cnt_n;
      live       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qupls4_fetch_ip_sequencer.sv
// Directed bench for qupls4_fetch_ip_sequencer with a bundle scoreboard.
module tb_qupls4_fetch_ip_sequencer;

  localparam logic [31:0] RSTIP = 32'hFFFFFD00;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_ip = '0;
  logic          ic_req;
  logic [31:0]   ic_ip;
  logic          ic_valid = 1'b0;
  logic [31:0]   ic_rsp_ip = '0;
  logic [1023:0] ic_line = '0;
  logic [1023:0] cline_o;
  logic [31:0]   ip_o;
  logic [9:0]    nops_i = '0;
  logic [6:0]    ip_inc_i = 7'd24;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_ip;
  logic [191:0]  out_inst;
  logic [3:0]    out_nop;
  logic [31:0]   bundle_cnt;

  qupls4_fetch_ip_sequencer #(.MWIDTH(4), .PCW(32), .RSTIP(RSTIP)) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_ip(redirect_ip),
    .ic_req(ic_req), .ic_ip(ic_ip),
    .ic_valid(ic_valid), .ic_rsp_ip(ic_rsp_ip), .ic_line(ic_line),
    .cline_o(cline_o), .ip_o(ip_o),
    .nops_i(nops_i), .ip_inc_i(ip_inc_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ip(out_ip), .out_inst(out_inst), .out_nop(out_nop),
    .bundle_cnt(bundle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  ip;
    logic [191:0] inst;
    logic [3:0]   nop;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total = 0;
  logic [31:0] exp_ip = RSTIP;
  logic [31:0] exp_cnt = 0;

  task automatic chk(input string tag, input logic [255:0] o,
                     input logic [255:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  function automatic logic [1023:0] mk_line(input logic [31:0] s);
    logic [1023:0] r;
    for (int i = 0; i < 32; i++)
      r[i*32+:32] = s * 32'h9E3779B9 + 32'(i);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] rip, input logic [31:0] seed,
                      input bit push);
    logic [1023:0] l;
    l = mk_line(seed);
    ic_valid = 1'b1;
    ic_rsp_ip = rip;
    ic_line = l;
    if (push) sb.push_back('{rip, l[191:0], nops_i[3:0]});
    cyc();
    ic_valid = 1'b0;
  endtask

  task automatic deliver(input string tag);
    exp_t e;
    logic [31:0] inc;
    chk({tag, "_sb"}, 256'(sb.size()), 256'(1));
    e = (sb.size() != 0) ? sb.pop_front() : '{32'hx, 192'hx, 4'hx};
    out_ready = 1'b1;
    #1;
    chk({tag, "_valid"}, 256'(out_valid), 256'(1));
    chk({tag, "_ip"}, 256'(out_ip), 256'(e.ip));
    chk({tag, "_inst"}, 256'(out_inst), 256'(e.inst));
    chk({tag, "_nop"}, 256'(out_nop), 256'(e.nop));
    inc = (ip_inc_i == 7'd0) ? 32'd6 : 32'(ip_inc_i);
    cyc();
    out_ready = 1'b0;
    exp_ip = exp_ip + inc;
    exp_cnt = exp_cnt + 1;
    #1;
    chk({tag, "_cnt"}, 256'(bundle_cnt), 256'(exp_cnt));
    chk({tag, "_req"}, 256'(ic_req), 256'(1));
    chk({tag, "_icip"}, 256'(ic_ip), 256'(exp_ip));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_req", 256'(ic_req), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_cnt", 256'(bundle_cnt), 256'(0));
    chk("rst_ip", 256'(ip_o), 256'(RSTIP));
    chk("rst_cline", 256'(cline_o[255:0]), 256'(0));
    #10 rst = 1'b0;
    cyc();
    chk("t1_req", 256'(ic_req), 256'(1));
    chk("t1_icip", 256'(ic_ip), 256'(RSTIP));

    // 1: first line and bundle
    nops_i = 10'd0;
    ip_inc_i = 7'd24;
    load(RSTIP, 32'd1, 1'b1);
    #1 chk("t1_dlv_valid", 256'(out_valid), 256'(1));
    chk("t1_dlv_req", 256'(ic_req), 256'(0));
    deliver("t1");

    // 2: stall with out_ready low
    nops_i = 10'b0000001001;
    load(exp_ip, 32'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_valid", 256'(out_valid), 256'(1));
      chk("t2_inst", 256'(out_inst), 256'(sb[0].inst));
      chk("t2_ip", 256'(ip_o), 256'(exp_ip));
      chk("t2_cnt", 256'(bundle_cnt), 256'(exp_cnt));
      cyc();
    end
    chk("t2_cline", 256'(cline_o[1023:768]),
        256'(mk_line(32'd2) >> 768));
    deliver("t2");

    // 3: nop mask
    nops_i = 10'b0000000110;
    ip_inc_i = 7'd24;
    load(exp_ip, 32'd3, 1'b1);
    #1 chk("t3_nop", 256'(out_nop), 256'(4'b0110));
    deliver("t3");

    // 4: redirect while a bundle is offered and ready is high
    nops_i = 10'd0;
    load(exp_ip, 32'd4, 1'b1);
    out_ready = 1'b1;
    redirect_i = 1'b1;
    redirect_ip = 32'h1000;
    #1 chk("t4_valid", 256'(out_valid), 256'(0));
    cyc();
    redirect_i = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_front());
    exp_ip = 32'h1000;
    #1;
    chk("t4_cnt", 256'(bundle_cnt), 256'(exp_cnt));
    chk("t4_req", 256'(ic_req), 256'(1));
    chk("t4_icip", 256'(ic_ip), 256'(32'h1000));

    // 5: stale response dropped, then matching one accepted
    load(exp_ip - 32'd6, 32'd5, 1'b0);
    #1;
    chk("t5_stale_req", 256'(ic_req), 256'(1));
    chk("t5_stale_valid", 256'(out_valid), 256'(0));
    // matching response in a redirect cycle is dropped too
    redirect_i = 1'b1;
    redirect_ip = 32'h2000;
    load(exp_ip, 32'd6, 1'b0);
    redirect_i = 1'b0;
    exp_ip = 32'h2000;
    #1;
    chk("t5_rdr_req", 256'(ic_req), 256'(1));
    chk("t5_rdr_icip", 256'(ic_ip), 256'(32'h2000));
    load(exp_ip, 32'd7, 1'b1);
    deliver("t5");

    // 6: wrap, zero increment, reset mid-delivery
    redirect_i = 1'b1;
    redirect_ip = 32'hFFFFFFFA;
    cyc();
    redirect_i = 1'b0;
    exp_ip = 32'hFFFFFFFA;
    ip_inc_i = 7'd6;
    load(exp_ip, 32'd8, 1'b1);
    deliver("t6w");
    chk("t6_wrap", 256'(ip_o), 256'(0));
    ip_inc_i = 7'd0;
    load(exp_ip, 32'd9, 1'b1);
    deliver("t6z");
    chk("t6_zinc", 256'(ip_o), 256'(6));
    ip_inc_i = 7'd24;
    load(exp_ip, 32'd10, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 256'(out_valid), 256'(0));
    chk("t6_rst_ip", 256'(ip_o), 256'(RSTIP));
    chk("t6_rst_cnt", 256'(bundle_cnt), 256'(0));
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_post_req", 256'(ic_req), 256'(1));
    chk("t6_post_icip", 256'(ic_ip), 256'(RSTIP));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
